// File: rtl/dac_spi_out.sv
// dac_spi_out: converts a signed filter sample into a 12-bit offset-binary DAC
// code and ships it as a 16-bit SPI frame (4'b0000, code[11:0], MSB first).
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   y_in     signed filter sample, cant_bits wide
//   y_valid  one-cycle strobe qualifying y_in
//   sclk     SPI clock, idles high; DAC samples sdata on the falling edge
//   sync_n   active-low frame select
//   sdata    serial data
//   busy     frame/gap in progress or a sample is pending
//   done     one-cycle pulse at frame completion
//   overrun  one-cycle pulse when a pending sample is overwritten
module dac_spi_out #(
  parameter int cant_bits = 25,
  parameter int shift     = 8,
  parameter int div       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [cant_bits-1:0] y_in,
  input  logic                 y_valid,
  output logic                 sclk,
  output logic                 sync_n,
  output logic                 sdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [7:0] DIV_LAST = 8'(div - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * div - 1);

  localparam logic signed [cant_bits-1:0] SAT_HI = {{(cant_bits-12){1'b0}}, 12'h7FF};
  localparam logic signed [cant_bits-1:0] SAT_LO = {{(cant_bits-12){1'b1}}, 12'h800};

  // Sample conversion: arithmetic shift, clamp to 12-bit signed range, then
  // offset by 2048 (equivalent to flipping the sign bit of the clamped value).
  logic signed [cant_bits-1:0] t_s;
  logic [11:0]                 code;

  assign t_s = $signed(y_in) >>> shift;

  always_comb begin
    if (t_s > SAT_HI)      code = 12'hFFF;
    else if (t_s < SAT_LO) code = 12'h000;
    else                   code = {~t_s[11], t_s[10:0]};
  end

  logic [1:0]  state_q, state_d;
  logic [11:0] pend_q,  pend_d;
  logic        full_q,  full_d;
  logic [15:0] sr_q,    sr_d;
  logic [3:0]  bit_q,   bit_d;
  logic [7:0]  div_q,   div_d;
  logic [8:0]  gap_q,   gap_d;
  logic        sclk_q,  sclk_d;
  logic        sync_n_q, sync_n_d;
  logic        sdata_q, sdata_d;
  logic        done_q,  done_d;
  logic        ovr_q,   ovr_d;
  logic        consume;
  logic [15:0] frame;

  assign consume = (state_q == S_IDLE) && full_q;
  assign frame   = {4'b0000, pend_q};

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    full_d   = full_q;
    sr_d     = sr_q;
    bit_d    = bit_q;
    div_d    = div_q;
    gap_d    = gap_q;
    sclk_d   = sclk_q;
    sync_n_d = sync_n_q;
    sdata_d  = sdata_q;
    done_d   = 1'b0;
    ovr_d    = 1'b0;

    // Pending slot: a strobe on the consuming edge refills it without overrun.
    if (y_valid) pend_d = code;
    if (consume) full_d = y_valid;
    else         full_d = full_q | y_valid;
    ovr_d = y_valid && full_q && !consume;

    case (state_q)
      S_IDLE: begin
        if (full_q) begin
          sr_d     = frame;
          state_d  = S_SHIFT;
          sync_n_d = 1'b0;
          sdata_d  = frame[15];
          sclk_d   = 1'b1;
          bit_d    = 4'd15;
          div_d    = 8'd0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = 8'd0;
          sclk_d = ~sclk_q;
          // Falling toggle keeps sdata; rising toggle advances or ends frame.
          if (!sclk_q) begin
            if (bit_q != 4'd0) begin
              bit_d   = bit_q - 4'd1;
              sdata_d = sr_q[bit_q - 4'd1];
            end else begin
              sync_n_d = 1'b1;
              sdata_d  = 1'b0;
              done_d   = 1'b1;
              state_d  = S_GAP;
              gap_d    = 9'd0;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = 9'd0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= 12'd0;
      full_q   <= 1'b0;
      sr_q     <= 16'd0;
      bit_q    <= 4'd0;
      div_q    <= 8'd0;
      gap_q    <= 9'd0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      sdata_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      full_q   <= full_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      gap_q    <= gap_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      sdata_q  <= sdata_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  assign sclk    = sclk_q;
  assign sync_n  = sync_n_q;
  assign sdata   = sdata_q;
  assign done    = done_q;
  assign overrun = ovr_q;
  assign busy    = (state_q != S_IDLE) || full_q;

endmodule

// File: tb/tb_dac_spi_out.sv
// Scoreboard bench for dac_spi_out. Stimulus runs a transaction-timeline model
// (when will the pending sample be taken, is it overwritten) and pushes the
// expected frame words; an independent monitor reassembles frames from the
// SPI pins on sclk falling edges and checks them against the queue.
module tb_dac_spi_out;

  localparam int DIV   = 4;
  localparam int FRAME = 34 * DIV;   // frame plus gap, in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [24:0] y_in = '0;
  logic        y_valid = 1'b0;
  logic        sclk, sync_n, sdata, busy, done, overrun;

  dac_spi_out #(.cant_bits(25), .shift(8), .div(DIV)) dut (
    .clk(clk), .rst(rst), .y_in(y_in), .y_valid(y_valid),
    .sclk(sclk), .sync_n(sync_n), .sdata(sdata), .busy(busy),
    .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference conversion: floor(y / 256), clamp, offset binary.
  function automatic logic [11:0] ref_code(input logic [24:0] v);
    int y, t;
    y = int'($signed(v));
    t = y >>> 8;
    if (t > 2047)  t = 2047;
    if (t < -2048) t = -2048;
    return 12'(t + 2048);
  endfunction

  // ---------------- timeline model ----------------
  logic [15:0] exp_q[$];
  int          exp_ovr    = 0;
  bit          pend_v     = 0;
  logic [11:0] pend_code  = '0;
  int          pend_arr   = 0;
  int          idle_edge  = 0;   // first edge on which a new frame may start

  function automatic int take_edge();
    return (pend_arr + 1 > idle_edge) ? pend_arr + 1 : idle_edge;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (pend_v && take_edge() <= cyc) begin
      exp_q.push_back({4'b0000, pend_code});
      idle_edge = take_edge() + FRAME + 1;
      pend_v = 0;
    end
  endtask

  task automatic send(input logic [24:0] v);
    int c;
    c = cyc + 1;
    if (pend_v) begin
      if (take_edge() == c) begin
        exp_q.push_back({4'b0000, pend_code});
        idle_edge = c + FRAME + 1;
      end else begin
        exp_ovr++;
      end
    end
    pend_v = 1; pend_code = ref_code(v); pend_arr = c;
    y_in = v; y_valid = 1'b1;
    tick();
    y_valid = 1'b0;
    y_in = $urandom;   // ignored while y_valid is low
  endtask

  task automatic do_reset(input bit with_valid);
    rst = 1'b1;
    if (with_valid) begin y_valid = 1'b1; y_in = 25'h0012345; end
    tick();
    rst = 1'b0; y_valid = 1'b0;
    pend_v = 0;
    idle_edge = cyc + 1;
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || pend_v) && n < 2000) begin tick(); n++; end
    chk({name, "_idle_timeout"}, int'(n >= 2000), 0);
    chk({name, "_exp_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  int          done_cnt = 0, ovr_cnt = 0, frames = 0;
  bit          in_frame = 0;
  bit          prev_sclk = 1;
  int          low_cnt, nbits;
  logic [15:0] word;

  always @(negedge clk) begin
    if (done)    done_cnt++;
    if (overrun) ovr_cnt++;
    if (rst) begin
      in_frame = 0;
    end else if (!sync_n) begin
      if (!in_frame) begin in_frame = 1; low_cnt = 0; nbits = 0; word = '0; end
      low_cnt++;
      if (prev_sclk && !sclk) begin word = {word[14:0], sdata}; nbits++; end
    end else if (in_frame) begin
      in_frame = 0;
      frames++;
      chk("frame_bits", nbits, 16);
      chk("sync_low_cycles", low_cnt, 32 * DIV);
      chk("done_at_frame_end", int'(done), 1);
      if (exp_q.size() == 0) chk("unexpected_frame", int'(word), -1);
      else chk("frame_word", int'(word), int'(exp_q.pop_front()));
    end
    prev_sclk = sclk;
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, o0, d0, r;
    logic [24:0] v;

    tick(); tick();
    do_reset(1'b0);
    chk("rst_sclk", int'(sclk), 1);
    chk("rst_sync_n", int'(sync_n), 1);
    chk("rst_sdata", int'(sdata), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);

    // valid during reset is dropped
    do_reset(1'b1);
    tick();
    chk("rst_valid_dropped_busy", int'(busy), 0);
    chk("rst_valid_dropped_sync", int'(sync_n), 1);

    // zero sample: latency, done, busy tail
    send(25'h0);
    chk("sync_not_before_sample", int'(sync_n), 1);
    tick();
    r = int'(sync_n);
    tick();
    chk("sync_low_latency", int'(sync_n), 0);
    chk("busy_in_frame", int'(busy), 1);
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk("done_timeout", int'(n >= 400), 0);
    n = 0;
    while (busy && n < 100) begin tick(); n++; end
    chk("busy_fall_after_done", n, 2 * DIV);
    wait_idle("zero");

    // conversion corners
    send(25'h0000100);  wait_idle("p801");
    send(25'h1FFFFFF);  wait_idle("m7ff");
    send(25'h0FFFFFF);  wait_idle("satp");
    send(25'h1000000);  wait_idle("satn");

    // A, B, C ten cycles apart: B overwritten by C
    o0 = ovr_cnt;
    send(25'h0001200);
    repeat (9) tick();
    send(25'h0003400);
    repeat (9) tick();
    send(25'h1FF5600);
    wait_idle("abc");
    chk("abc_overrun_once", ovr_cnt - o0, 1);

    // new sample on the exact edge the pending one is taken
    send(25'h0000A00);
    repeat (5) tick();
    send(25'h0000B00);
    n = 0;
    while (cyc + 1 != take_edge() && n < 400) begin tick(); n++; end
    o0 = ovr_cnt;
    send(25'h0000C00);
    tick();
    chk("same_edge_no_overrun", ovr_cnt - o0, 0);
    wait_idle("same_edge");

    // abort mid-frame
    d0 = done_cnt;
    send(25'h0007700);
    repeat (60) tick();
    do_reset(1'b0);
    chk("abort_sync_n", int'(sync_n), 1);
    chk("abort_sclk", int'(sclk), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (10) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    send(25'h1F00000);
    wait_idle("after_abort");

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: v = 25'($urandom);
        1: v = 25'($urandom_range(0, 8191)) - 25'd4096;
        default: v = $urandom_range(0, 1) ? 25'h0FFFFFF - 25'($urandom_range(0, 600))
                                          : 25'h1000000 + 25'($urandom_range(0, 600));
      endcase
      send(v);
      case ($urandom_range(0, 3))
        0: n = $urandom_range(0, 30);
        1: n = FRAME - 6 + $urandom_range(0, 12);
        2: n = FRAME + $urandom_range(5, 60);
        default: n = 0;
      endcase
      repeat (n) tick();
    end
    wait_idle("random");

    chk("overrun_total", ovr_cnt, exp_ovr);
    chk("done_total", done_cnt, frames);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
